hermes_switch_control: RTL and testbench



---
 rtl/hermes_switch_control_pkg.sv | 40 ++++
 rtl/hermes_switch_control_if.sv | 29 ++
 rtl/hermes_switch_control_rr_arbiter.sv | 27 ++
 rtl/hermes_switch_control.sv | 133 +++++++++++++
 tb/tb_hermes_switch_control.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hermes_switch_control_pkg.sv
// rtl/hermes_switch_control_pkg.sv - Hermes router port map, header field layout and XY routing
package hermes_pkg;

   localparam int NPORT = 5;

   typedef logic [2:0] port_t;

   typedef enum port_t {
      EAST  = 3'd0,
      WEST  = 3'd1,
      NORTH = 3'd2,
      SOUTH = 3'd3,
      LOCAL = 3'd4
   } port_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUTE = 2'd1,
      S_GRANT = 2'd2
   } state_e;

   localparam int HDR_X_LSB   = 8;
   localparam int HDR_Y_LSB   = 0;
   localparam int HDR_FIELD_W = 8;

   // Dimension-ordered routing: resolve X fully before Y, LOCAL when both match.
   function automatic port_t xy_route(input logic [15:0] hdr, input logic [15:0] addr);
      logic [HDR_FIELD_W-1:0] tx, ty, x, y;
      tx = hdr[HDR_X_LSB +: HDR_FIELD_W];
      ty = hdr[HDR_Y_LSB +: HDR_FIELD_W];
      x  = addr[HDR_X_LSB +: HDR_FIELD_W];
      y  = addr[HDR_Y_LSB +: HDR_FIELD_W];
      if (tx > x) return EAST;
      if (tx < x) return WEST;
      if (ty > y) return NORTH;
      if (ty < y) return SOUTH;
      return LOCAL;
   endfunction

endpackage

// File: rtl/hermes_switch_control_if.sv
// rtl/hermes_switch_control_if.sv - input-buffer/crossbar side signals of the switch controller
interface hermes_switch_control_if #(
   parameter int NPORT     = 5,
   parameter int FLIT_SIZE = 32
);
   import hermes_pkg::*;

   localparam int PW = $bits(port_t);

   logic [NPORT-1:0]           req;
   logic [NPORT*FLIT_SIZE-1:0] header;
   logic [NPORT-1:0]           active;
   logic [NPORT-1:0]           req_ack;
   logic [NPORT*PW-1:0]        out_sel;
   logic [NPORT-1:0]           out_valid;
   logic [NPORT*PW-1:0]        in_sel;
   logic [NPORT-1:0]           out_busy;

   modport master (
      output req, header, active,
      input  req_ack, out_sel, out_valid, in_sel, out_busy
   );

   modport slave (
      input  req, header, active,
      output req_ack, out_sel, out_valid, in_sel, out_busy
   );

endinterface

// File: rtl/hermes_switch_control_rr_arbiter.sv
// rtl/hermes_switch_control_rr_arbiter.sv - combinational round-robin pick, first requester after last_i
module hermes_rr_arbiter #(
   parameter int NPORT = 5
) (
   input  logic [NPORT-1:0]  req_i,
   input  hermes_pkg::port_t last_i,
   output logic              gnt_valid_o,
   output hermes_pkg::port_t gnt_idx_o
);
   import hermes_pkg::*;

   int cand;

   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      cand        = 0;
      for (int k = 1; k <= NPORT; k++) begin
         cand = (int'(last_i) + k) % NPORT;
         if (!gnt_valid_o && req_i[cand]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = port_t'(cand);
         end
      end
   end

endmodule

// File: rtl/hermes_switch_control.sv
// rtl/hermes_switch_control.sv - Hermes router arbitration, XY routing and crossbar table control
module hermes_switch_control #(
   parameter int          NPORT     = 5,
   parameter int          FLIT_SIZE = 32,
   parameter logic [15:0] ADDRESS   = 16'h0000
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   hermes_switch_control_if.slave bus
);
   import hermes_pkg::*;

   localparam int PW = $bits(port_t);

   state_e state_q, state_d;
   port_t  sel_q, sel_d;
   port_t  dir_q, dir_d;
   port_t  ptr_q, ptr_d;

   logic [NPORT-1:0]    out_valid_q, out_valid_d;
   logic [NPORT-1:0]    out_busy_q,  out_busy_d;
   logic [NPORT-1:0]    armed_q,     armed_d;
   logic [NPORT*PW-1:0] out_sel_q,   out_sel_d;
   logic [NPORT*PW-1:0] in_sel_q,    in_sel_d;

   logic        arb_valid;
   port_t       arb_idx;
   logic [15:0] sel_hdr;
   port_t       route_dir;

   hermes_rr_arbiter #(.NPORT(NPORT)) u_arb (
      .req_i       (bus.req),
      .last_i      (ptr_q),
      .gnt_valid_o (arb_valid),
      .gnt_idx_o   (arb_idx)
   );

   // Only the low 16 bits of the head flit carry the XY target.
   assign sel_hdr   = bus.header[int'(sel_q)*FLIT_SIZE +: 16];
   assign route_dir = xy_route(sel_hdr, ADDRESS);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         dir_q       <= '0;
         ptr_q       <= port_t'(NPORT-1);
         out_valid_q <= '0;
         out_busy_q  <= '0;
         armed_q     <= '0;
         out_sel_q   <= '0;
         in_sel_q    <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         dir_q       <= dir_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_busy_q  <= out_busy_d;
         armed_q     <= armed_d;
         out_sel_q   <= out_sel_d;
         in_sel_q    <= in_sel_d;
      end
   end

   // A blocked request moves the pointer to itself so the others get a turn first.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      dir_d   = dir_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         S_IDLE: begin
            if (arb_valid) begin
               sel_d   = arb_idx;
               state_d = S_ROUTE;
            end
         end
         S_ROUTE: begin
            if (!out_busy_q[route_dir]) begin
               dir_d   = route_dir;
               state_d = S_GRANT;
            end else begin
               ptr_d   = sel_q;
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            ptr_d   = sel_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Release needs one active cycle first, so a gap before the packet starts keeps the path.
   always_comb begin
      out_valid_d = out_valid_q;
      out_busy_d  = out_busy_q;
      armed_d     = armed_q;
      out_sel_d   = out_sel_q;
      in_sel_d    = in_sel_q;
      for (int i = 0; i < NPORT; i++) begin
         if (armed_q[i] && !bus.active[i]) begin
            out_valid_d[i]                       = 1'b0;
            out_busy_d[out_sel_q[i*PW +: PW]]    = 1'b0;
            armed_d[i]                           = 1'b0;
         end else if (out_valid_q[i] && bus.active[i]) begin
            armed_d[i] = 1'b1;
         end
      end
      if (state_q == S_GRANT) begin
         out_busy_d[dir_q]                 = 1'b1;
         in_sel_d[int'(dir_q)*PW +: PW]    = sel_q;
         out_sel_d[int'(sel_q)*PW +: PW]   = dir_q;
         out_valid_d[sel_q]                = 1'b1;
         armed_d[sel_q]                    = 1'b0;
      end
   end

   always_comb begin
      bus.req_ack = '0;
      if (state_q == S_GRANT) begin
         bus.req_ack[sel_q] = 1'b1;
      end
   end

   assign bus.out_sel   = out_sel_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_sel    = in_sel_q;
   assign bus.out_busy  = out_busy_q;

endmodule

// File: tb/tb_hermes_switch_control.sv
// tb/tb_hermes_switch_control.sv - directed and randomized bench for hermes_switch_control
module tb_hermes_switch_control;

   localparam int          NP   = 5;
   localparam int          FW   = 32;
   localparam logic [15:0] ADDR = 16'h0101;

   logic clk    = 1'b0;
   logic rst_ni = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   hermes_switch_control_if #(.NPORT(NP), .FLIT_SIZE(FW)) bus ();

   hermes_switch_control #(.NPORT(NP), .FLIT_SIZE(FW), .ADDRESS(ADDR)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_hdr(input int p, input logic [15:0] h);
      bus.header[p*FW +: FW] = {16'h0000, h};
   endtask

   function automatic logic [2:0] slot(input logic [NP*3-1:0] v, input int i);
      return v[i*3 +: 3];
   endfunction

   // Leaves the bench at the negedge of cycle 0 with reset released.
   task automatic do_reset();
      rst_ni     = 1'b0;
      bus.req    = '0;
      bus.active = '0;
      bus.header = '0;
      cyc();
      cyc();
      rst_ni = 1'b1;
   endtask

   function automatic int ref_route(input logic [15:0] h);
      int dx, dy;
      dx = int'(h[15:8]) - int'(ADDR[15:8]);
      dy = int'(h[7:0])  - int'(ADDR[7:0]);
      if (dx > 0) return 0;
      if (dx < 0) return 1;
      if (dy > 0) return 2;
      if (dy < 0) return 3;
      return 4;
   endfunction

   task automatic test_reset();
      rst_ni     = 1'b0;
      bus.req    = '1;
      bus.active = '1;
      bus.header = '0;
      cyc();
      n_tests++;
      if (bus.req_ack !== 5'b0 || bus.out_busy !== 5'b0 || bus.out_valid !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: ack=%b busy=%b valid=%b want all 0", bus.req_ack, bus.out_busy, bus.out_valid);
      end
      n_tests++;
      if (bus.in_sel !== 15'b0 || bus.out_sel !== 15'b0) begin
         n_fail++;
         $display("FAIL reset_tables: in_sel=%h out_sel=%h want 0", bus.in_sel, bus.out_sel);
      end
   endtask

   task automatic test_local_to_east();
      do_reset();
      set_hdr(4, 16'h0201);
      bus.req[4] = 1'b1;
      for (int c = 0; c <= 2; c++) begin
         n_tests++;
         if (bus.req_ack !== ((c == 2) ? 5'b10000 : 5'b00000)) begin
            n_fail++;
            $display("FAIL t1_ack_c%0d: got %b want %b", c, bus.req_ack, (c == 2) ? 5'b10000 : 5'b00000);
         end
         if (c == 2) bus.req[4] = 1'b0;
         cyc();
      end
      n_tests++;
      if (slot(bus.in_sel, 0) !== 3'd4 || slot(bus.out_sel, 4) !== 3'd0) begin
         n_fail++;
         $display("FAIL t1_tables: in_sel[E]=%0d out_sel[L]=%0d want 4 0", slot(bus.in_sel, 0), slot(bus.out_sel, 4));
      end
      n_tests++;
      if (bus.out_busy !== 5'b00001 || bus.out_valid !== 5'b10000 || bus.req_ack !== 5'b0) begin
         n_fail++;
         $display("FAIL t1_flags: busy=%b valid=%b ack=%b want 00001 10000 00000", bus.out_busy, bus.out_valid, bus.req_ack);
      end
   endtask

   task automatic test_release();
      cyc();
      n_tests++;
      if (bus.out_busy !== 5'b00001 || bus.out_valid !== 5'b10000) begin
         n_fail++;
         $display("FAIL t2_gap_hold: busy=%b valid=%b want 00001 10000", bus.out_busy, bus.out_valid);
      end
      bus.active[4] = 1'b1;
      repeat (4) cyc();
      bus.active[4] = 1'b0;
      n_tests++;
      if (bus.out_busy !== 5'b00001) begin
         n_fail++;
         $display("FAIL t2_fall_cycle: busy=%b want 00001", bus.out_busy);
      end
      cyc();
      n_tests++;
      if (bus.out_busy !== 5'b00000 || bus.out_valid !== 5'b00000) begin
         n_fail++;
         $display("FAIL t2_released: busy=%b valid=%b want 0 0", bus.out_busy, bus.out_valid);
      end
   endtask

   task automatic test_two_requests();
      logic [4:0] want;
      do_reset();
      set_hdr(0, 16'h0001);
      set_hdr(2, 16'h0102);
      bus.req[0] = 1'b1;
      bus.req[2] = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         want = (c == 2) ? 5'b00001 : ((c == 5) ? 5'b00100 : 5'b00000);
         n_tests++;
         if (bus.req_ack !== want) begin
            n_fail++;
            $display("FAIL t3_ack_c%0d: got %b want %b", c, bus.req_ack, want);
         end
         if (c == 2) bus.req[0] = 1'b0;
         if (c == 5) bus.req[2] = 1'b0;
         cyc();
      end
      n_tests++;
      if (bus.out_busy !== 5'b00110 || bus.out_valid !== 5'b00101) begin
         n_fail++;
         $display("FAIL t3_flags: busy=%b valid=%b want 00110 00101", bus.out_busy, bus.out_valid);
      end
      n_tests++;
      if (slot(bus.out_sel, 0) !== 3'd1 || slot(bus.out_sel, 2) !== 3'd2 ||
          slot(bus.in_sel, 1) !== 3'd0 || slot(bus.in_sel, 2) !== 3'd2) begin
         n_fail++;
         $display("FAIL t3_tables: out_sel=%h in_sel=%h want out0=1 out2=2 in1=0 in2=2", bus.out_sel, bus.in_sel);
      end
   endtask

   task automatic test_blocked();
      int k;
      do_reset();
      set_hdr(1, 16'h0101);
      set_hdr(3, 16'h0101);
      bus.req[1] = 1'b1;
      bus.req[3] = 1'b1;
      cyc();
      cyc();
      n_tests++;
      if (bus.req_ack !== 5'b00010) begin
         n_fail++;
         $display("FAIL t4_first_grant: got %b want 00010", bus.req_ack);
      end
      bus.req[1] = 1'b0;
      for (int c = 3; c <= 11; c++) begin
         cyc();
         n_tests++;
         if (bus.req_ack !== 5'b0 || bus.out_busy !== 5'b10000) begin
            n_fail++;
            $display("FAIL t4_blocked_c%0d: ack=%b busy=%b want 00000 10000", c, bus.req_ack, bus.out_busy);
         end
      end
      bus.active[1] = 1'b1;
      cyc();
      bus.active[1] = 1'b0;
      cyc();
      n_tests++;
      if (bus.out_busy !== 5'b00000) begin
         n_fail++;
         $display("FAIL t4_release: busy=%b want 00000", bus.out_busy);
      end
      k = 0;
      while (bus.req_ack !== 5'b01000 && k < 6) begin
         cyc();
         k++;
      end
      n_tests++;
      if (k > 3) begin
         n_fail++;
         $display("FAIL t4_retry_latency: got %0d cycles want <=3", k);
      end
      bus.req[3] = 1'b0;
      cyc();
      n_tests++;
      if (slot(bus.in_sel, 4) !== 3'd3 || bus.out_busy !== 5'b10000) begin
         n_fail++;
         $display("FAIL t4_retry_table: in_sel[L]=%0d busy=%b want 3 10000", slot(bus.in_sel, 4), bus.out_busy);
      end
   endtask

   task automatic test_local_dest();
      do_reset();
      set_hdr(2, ADDR);
      bus.req[2] = 1'b1;
      cyc();
      cyc();
      bus.req[2] = 1'b0;
      cyc();
      n_tests++;
      if (slot(bus.in_sel, 4) !== 3'd2 || slot(bus.out_sel, 2) !== 3'd4 || bus.out_busy !== 5'b10000) begin
         n_fail++;
         $display("FAIL t5_local: in_sel[L]=%0d out_sel[N]=%0d busy=%b want 2 4 10000",
                  slot(bus.in_sel, 4), slot(bus.out_sel, 2), bus.out_busy);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_hdr(0, 16'h0001);
      set_hdr(3, 16'h0201);
      bus.req[0] = 1'b1;
      bus.req[3] = 1'b1;
      cyc();
      cyc();
      bus.req[0] = 1'b0;
      repeat (3) cyc();
      n_tests++;
      if (bus.req_ack !== 5'b01000 || bus.out_busy !== 5'b00010) begin
         n_fail++;
         $display("FAIL t6_pre_reset: ack=%b busy=%b want 01000 00010", bus.req_ack, bus.out_busy);
      end
      #2 rst_ni = 1'b0;
      #1;
      n_tests++;
      if (bus.req_ack !== 5'b0 || bus.out_busy !== 5'b0 || bus.out_valid !== 5'b0) begin
         n_fail++;
         $display("FAIL t6_async_reset: ack=%b busy=%b valid=%b want all 0", bus.req_ack, bus.out_busy, bus.out_valid);
      end
      bus.req = '0;
      set_hdr(2, 16'h0102);
      bus.req[2] = 1'b1;
      bus.req[3] = 1'b1;
      cyc();
      rst_ni = 1'b1;
      cyc();
      cyc();
      n_tests++;
      if (bus.req_ack !== 5'b00100) begin
         n_fail++;
         $display("FAIL t6_first_after_reset: got %b want 00100", bus.req_ack);
      end
      bus.req = '0;
   endtask

   // Event-scheduled reference: a decision picks at dec_at, routes one cycle later,
   // then either grants the cycle after or returns to picking.
   task automatic test_random();
      int m_busy[NP], m_valid[NP], m_armed[NP], m_route[NP], m_in[NP];
      int nb[NP], nv[NP], na[NP];
      int st[NP], wait_c[NP], gap[NP], hi[NP];
      logic [15:0] hdr[NP];
      logic [NP-1:0] act, rq, exp_ack, exp_busy, exp_valid;
      logic [NP*3-1:0] exp_in, exp_out;
      int ptr, dec_at, route_at, grant_at, pick, gdir, gd, cand, prints;
      bit found;
      do_reset();
      for (int p = 0; p < NP; p++) begin
         m_busy[p] = 0; m_valid[p] = 0; m_armed[p] = 0; m_route[p] = 0; m_in[p] = 0;
         st[p] = 0; wait_c[p] = $urandom_range(0, 3); gap[p] = 0; hi[p] = 0; hdr[p] = '0;
      end
      ptr = NP - 1; dec_at = 0; route_at = -1; grant_at = -1; pick = 0; gdir = 0; prints = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < NP; p++) begin
            rq[p]  = (st[p] == 1);
            act[p] = (st[p] == 2 && gap[p] == 0 && hi[p] > 0);
            bus.header[p*FW +: FW] = {16'h0000, hdr[p]};
         end
         bus.req    = rq;
         bus.active = act;
         exp_ack = '0;
         if (grant_at == c) exp_ack[pick] = 1'b1;
         for (int p = 0; p < NP; p++) begin
            exp_busy[p]      = (m_busy[p] != 0);
            exp_valid[p]     = (m_valid[p] != 0);
            exp_in[p*3 +: 3]  = 3'(m_in[p]);
            exp_out[p*3 +: 3] = 3'(m_route[p]);
         end
         n_tests++;
         if ({bus.req_ack, bus.out_busy, bus.out_valid} !== {exp_ack, exp_busy, exp_valid}) begin
            n_fail++;
            if (prints++ < 20)
               $display("FAIL rnd_flags_c%0d: ack/busy/valid=%b %b %b want %b %b %b", c,
                        bus.req_ack, bus.out_busy, bus.out_valid, exp_ack, exp_busy, exp_valid);
         end
         n_tests++;
         if ({bus.in_sel, bus.out_sel} !== {exp_in, exp_out}) begin
            n_fail++;
            if (prints++ < 20)
               $display("FAIL rnd_tables_c%0d: in_sel=%h out_sel=%h want %h %h", c,
                        bus.in_sel, bus.out_sel, exp_in, exp_out);
         end
         nb = m_busy; nv = m_valid; na = m_armed;
         for (int i = 0; i < NP; i++) begin
            if (m_armed[i] != 0 && !act[i]) begin
               nv[i] = 0; nb[m_route[i]] = 0; na[i] = 0;
            end else if (m_valid[i] != 0 && act[i]) begin
               na[i] = 1;
            end
         end
         if (grant_at == c) begin
            nb[gdir] = 1; m_in[gdir] = pick; m_route[pick] = gdir; nv[pick] = 1; na[pick] = 0;
            ptr = pick; dec_at = c + 1;
         end else if (route_at == c) begin
            gd = ref_route(hdr[pick]);
            if (m_busy[gd] == 0) begin
               gdir = gd; grant_at = c + 1;
            end else begin
               ptr = pick; dec_at = c + 1;
            end
         end else if (dec_at == c) begin
            found = 1'b0;
            for (int k = 1; k <= NP; k++) begin
               cand = (ptr + k) % NP;
               if (!found && rq[cand]) begin
                  found = 1'b1; pick = cand;
               end
            end
            if (found) route_at = c + 1;
            else dec_at = c + 1;
         end
         m_busy = nb; m_valid = nv; m_armed = na;
         for (int p = 0; p < NP; p++) begin
            case (st[p])
               0: begin
                  if (wait_c[p] == 0) begin
                     st[p]  = 1;
                     hdr[p] = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))};
                  end else begin
                     wait_c[p]--;
                  end
               end
               1: begin
                  if (exp_ack[p]) begin
                     st[p] = 2; gap[p] = $urandom_range(0, 2); hi[p] = $urandom_range(1, 4);
                  end
               end
               default: begin
                  if (gap[p] > 0) gap[p]--;
                  else if (hi[p] > 0) hi[p]--;
                  else begin
                     st[p] = 0; wait_c[p] = $urandom_range(0, 5);
                  end
               end
            endcase
         end
         cyc();
      end
      bus.req    = '0;
      bus.active = '0;
   endtask

   initial begin
      test_reset();
      test_local_to_east();
      test_release();
      test_two_requests();
      test_blocked();
      test_local_dest();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
